// File: rtl/imem_refill_responder.sv
// I-cache refill responder: accepts one block request and streams the block back
// critical-word-first, wrapping within the block, from byte-organised storage.
module imem_refill_responder #(
    parameter int BLOCK_BYTES = 64,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int LATENCY     = 2,
    localparam int WORDS      = BLOCK_BYTES / WORD_BYTES,
    localparam int WIDX_W     = $clog2(WORDS),
    localparam int DATA_W     = WORD_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic [WIDX_W-1:0]     resp_beat,
    output logic                  resp_last,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [WORD_BYTES-1:0] wr_be
);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int BLK_AW = $clog2(BLOCK_BYTES);
    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int BLK_W  = MEM_AW - BLK_AW;
    localparam int WCW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t            state, state_nxt;
    logic [BLK_W-1:0]  blk;
    logic [WIDX_W-1:0] word_idx;
    logic [WIDX_W-1:0] beat_cnt;
    logic [WCW-1:0]    wait_cnt;
    logic [7:0]        mem [MEM_BYTES];

    logic              accept, hs, last, load_en;
    logic [BLK_W-1:0]  rd_blk;
    logic [WIDX_W-1:0] rd_word;
    logic [MEM_AW-1:0] rd_addr, wr_base;
    logic [DATA_W-1:0] rd_data;
    logic              unused_addr;

    assign accept     = (state == IDLE) && req_valid;
    assign hs         = resp_valid && resp_ready;
    assign last       = (beat_cnt == WIDX_W'(WORDS - 1));
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == SEND);
    assign resp_last  = (state == SEND) && last;
    assign resp_beat  = word_idx;
    assign unused_addr = ^{req_addr[ADDR_WIDTH-1:MEM_AW], req_addr[OFF_W-1:0],
                           wr_addr[ADDR_WIDTH-1:MEM_AW], wr_addr[OFF_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY > 0) ? WAIT : SEND;
            WAIT: if (wait_cnt == '0) state_nxt = SEND;
            SEND: if (hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The beat register is loaded on entry to SEND and on every non-final
    // handshake; with LATENCY=0 the address comes straight from the request.
    assign load_en = (state_nxt == SEND) && ((state != SEND) || (hs && !last));

    always_comb begin
        rd_blk  = blk;
        rd_word = word_idx + 1'b1;
        if (state == IDLE) begin
            rd_blk  = req_addr[MEM_AW-1:BLK_AW];
            rd_word = req_addr[BLK_AW-1:OFF_W];
        end else if (state == WAIT) begin
            rd_word = word_idx;
        end
    end

    assign rd_addr = {rd_blk, rd_word, OFF_W'(0)};

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < WORD_BYTES; b++)
            rd_data[8*b +: 8] = mem[rd_addr + MEM_AW'(b)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk       <= '0;
            word_idx  <= '0;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                blk      <= req_addr[MEM_AW-1:BLK_AW];
                word_idx <= req_addr[BLK_AW-1:OFF_W];
                beat_cnt <= '0;
                wait_cnt <= WCW'(LATENCY);
            end
            if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            if (load_en) resp_data <= rd_data;
            if (state == SEND && hs) begin
                word_idx <= word_idx + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Writes only land in IDLE with no request that cycle, so a burst always
    // reads a single storage snapshot.
    assign wr_base = {wr_addr[MEM_AW-1:OFF_W], OFF_W'(0)};

    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && !req_valid) begin
            for (int b = 0; b < WORD_BYTES; b++)
                if (wr_be[b]) mem[wr_base + MEM_AW'(b)] <= wr_data[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: ordering, latency, backpressure,
// busy interlock, byte enables, address wrap and mid-burst reset.
module tb_imem_refill_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [3:0]  resp_beat;
    logic        resp_last;
    logic        busy;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;

    imem_refill_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_beat(resp_beat), .resp_last(resp_last), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_d [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // bp_w: beat index to stall for 3 cycles; intl_k: burst position to inject a
    // request+write; rst_k: burst position after whose handshake reset fires.
    task automatic burst(input logic [31:0] a, input int bp_w, input int intl_k, input int rst_k);
        int lat;
        int s;
        int w;
        logic [31:0] hd;
        logic [3:0]  hb;
        logic        hl;
        s = int'(a[5:2]);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_drop", 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        for (int k = 0; k < 16; k++) begin
            w = (s + k) % 16;
            chk($sformatf("valid%0d", k), 32'(resp_valid), 32'd1);
            chk($sformatf("beat%0d", k), 32'(resp_beat), 32'(w));
            chk($sformatf("data%0d", k), resp_data, exp_d[w]);
            chk($sformatf("last%0d", k), 32'(resp_last), (k == 15) ? 32'd1 : 32'd0);
            if (w == bp_w) begin
                resp_ready = 1'b0;
                hd = resp_data; hb = resp_beat; hl = resp_last;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    chk("bp_valid", 32'(resp_valid), 32'd1);
                    chk("bp_data", resp_data, exp_d[w]);
                    chk("bp_beat", 32'(resp_beat), 32'(hb));
                    chk("bp_last", 32'(resp_last), 32'(hl));
                end
                chk("bp_hold", resp_data, hd);
                resp_ready = 1'b1;
            end
            if (k == intl_k) begin
                req_valid = 1'b1; req_addr = 32'h80;
                wr_en = 1'b1; wr_addr = (a & ~32'h3F) | 32'hC;
                wr_data = 32'hDEADBEEF; wr_be = 4'hF;
                chk("intl_ready", 32'(req_ready), 32'd0);
                chk("intl_busy", 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            req_valid = 1'b0; wr_en = 1'b0;
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", 32'(resp_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_last", 32'(resp_last), 32'd0);
                chk("rst_data", resp_data, 32'd0);
                #2 rst = 1'b0;
                #1;
                chk("rst_ready", 32'(req_ready), 32'd1);
                return;
            end
        end
        chk("end_valid", 32'(resp_valid), 32'd0);
        chk("end_ready", 32'(req_ready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        chk("r_ready", 32'(req_ready), 32'd1);
        chk("r_valid", 32'(resp_valid), 32'd0);
        chk("r_last", 32'(resp_last), 32'd0);
        chk("r_data", resp_data, 32'd0);
        chk("r_beat", 32'(resp_beat), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) wr(32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 16; i++)
            wr(32'h80 + 32'(4 * i), (i == 0) ? 32'h1122_3344 : 32'hB000_0000 + 32'(i), 4'hF);

        for (int i = 0; i < 16; i++) exp_d[i] = 32'hA000_0000 + 32'(i);
        burst(32'h40, -1, -1, -1);
        burst(32'h7E, -1, -1, -1);
        burst(32'h40, 5, -1, -1);
        burst(32'h40, -1, 8, -1);

        for (int i = 0; i < 16; i++) exp_d[i] = (i == 0) ? 32'h1122_3344 : 32'hB000_0000 + 32'(i);
        burst(32'h80, -1, -1, -1);

        wr(32'h80, 32'hAABB_CCDD, 4'b0101);
        exp_d[0] = 32'h11BB_33DD;
        burst(32'h80, -1, -1, -1);
        burst(32'h1080, -1, -1, -1);

        for (int i = 0; i < 16; i++) exp_d[i] = 32'hA000_0000 + 32'(i);
        burst(32'h40, -1, -1, 7);
        burst(32'h40, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
